// File: rtl/hc194_seq.sv
// Command sequencer driving an HC194 4-bit universal shift register.
// Accepts NOP/LOAD/shift/rotate commands and holds the '194 mode for the requested cycles.
module hc194_seq #(
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [0:3]       cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             ser_in,
    output logic             ser_rd,
    input  logic [0:3]       Q_in,
    output logic [1:0]       S,
    output logic             DSR,
    output logic             DSL,
    output logic [0:3]       D,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;
    localparam logic [2:0] OP_ROTL = 3'b101;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       s_q, s_d;
    logic [0:3]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    // Zero-length work (NOP, illegal, cnt==0) skips RUN entirely.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d = ST_RUN;
                            done_d  = 1'b0;
                            cnt_d   = CNT_ONE;
                            s_d     = S_LOAD;
                            data_d  = cmd_data;
                        end
                        OP_SHR, OP_ROTR, OP_SHL, OP_ROTL: begin
                            if (cmd_cnt != '0) begin
                                state_d = ST_RUN;
                                done_d  = 1'b0;
                                cnt_d   = cmd_cnt;
                                s_d     = (cmd_op == OP_SHR || cmd_op == OP_ROTR) ? S_RIGHT : S_LEFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    s_d     = S_HOLD;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = S_HOLD;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            s_q     <= S_HOLD;
            data_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    logic run;
    assign run = (state_q == ST_RUN);

    // Rotates recirculate the bit falling off the far end of the '194.
    assign DSR    = run && ((op_q == OP_SHR) ? ser_in : (op_q == OP_ROTR) ? Q_in[3] : 1'b0);
    assign DSL    = run && ((op_q == OP_SHL) ? ser_in : (op_q == OP_ROTL) ? Q_in[0] : 1'b0);
    assign ser_rd = run && (op_q == OP_SHR || op_q == OP_SHL);

    assign S         = s_q;
    assign D         = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_hc194_seq.sv
// Directed bench for hc194_seq with a behavioural HC194 closing the Q feedback loop.
module tb_hc194_seq;

    logic       CP = 1'b0;
    logic       MR;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [0:3] cmd_data;
    logic [3:0] cmd_cnt;
    logic       ser_in;
    logic       ser_rd;
    logic [0:3] q;
    logic [1:0] S;
    logic       DSR, DSL;
    logic [0:3] D;
    logic       busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CP = ~CP;

    hc194_seq #(.CNT_W(4)) dut (
        .CP(CP), .MR(MR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
        .ser_in(ser_in), .ser_rd(ser_rd), .Q_in(q), .S(S),
        .DSR(DSR), .DSL(DSL), .D(D), .busy(busy), .done(done)
    );

    // Behavioural HC194: Q[0] takes DSR on right shift, Q[3] takes DSL on left shift.
    always @(posedge CP or negedge MR) begin
        if (!MR) q <= 4'b0000;
        else begin
            case (S)
                2'b01:   q <= {DSR, q[0:2]};
                2'b10:   q <= {q[1:3], DSL};
                2'b11:   q <= D;
                default: q <= q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Issue one command, watch N+2 cycles, and check timing, mode and final Q.
    task automatic do_cmd(input string name, input logic [2:0] op, input logic [0:3] data,
                          input logic [3:0] cnt, input logic sin, input int n_exp,
                          input logic [1:0] s_exp, input logic rd_exp, input logic [0:3] q_exp);
        int nz_cycles = 0, bad_s = 0, rd_cycles = 0, done_cnt = 0, done_at = 0, ready_at = 0;
        logic busy1 = 1'b0;
        @(negedge CP);
        cmd_op = op; cmd_data = data; cmd_cnt = cnt; ser_in = sin; cmd_valid = 1'b1;
        check({name, ".ready_pre"}, cmd_ready, 1);
        for (int k = 1; k <= n_exp + 2; k++) begin
            @(negedge CP);
            cmd_valid = 1'b0;
            if (k == 1) busy1 = busy;
            if (S != 2'b00) nz_cycles++;
            if (S != 2'b00 && S != s_exp) bad_s++;
            if (ser_rd) rd_cycles++;
            if (done) begin done_cnt++; if (done_at == 0) done_at = k; end
            if (cmd_ready && ready_at == 0) ready_at = k;
        end
        check({name, ".busy"}, busy1, 1);
        check({name, ".s_cycles"}, nz_cycles, (s_exp == 2'b00) ? 0 : n_exp);
        check({name, ".s_code"}, bad_s, 0);
        check({name, ".ser_rd"}, rd_cycles, rd_exp ? n_exp : 0);
        check({name, ".done_at"}, done_at, n_exp + 1);
        check({name, ".done_cnt"}, done_cnt, 1);
        check({name, ".ready_at"}, ready_at, n_exp + 2);
        check({name, ".q"}, q, q_exp);
        $display("cmd %s op=%0d cnt=%0d Q=%b", name, op, cnt, q);
    endtask

    initial begin
        int first_rdy, done_cnt, done_first, done_last;
        MR = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 4'b0000;
        cmd_cnt = 4'd0; ser_in = 1'b0;
        repeat (2) @(posedge CP);
        @(negedge CP);
        check("rst.S", S, 0);
        check("rst.D", D, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.ready", cmd_ready, 1);
        check("rst.serial", {DSR, DSL, ser_rd}, 0);
        MR = 1'b1;
        $display("reset released");

        // Reset in the middle of SHR cnt=5.
        @(negedge CP);
        cmd_op = 3'b010; cmd_cnt = 4'd5; ser_in = 1'b1; cmd_valid = 1'b1;
        @(negedge CP);
        cmd_valid = 1'b0;
        check("abort.running", S, 1);
        @(negedge CP);
        MR = 1'b0;
        #1;
        check("abort.S", S, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.ready", cmd_ready, 1);
        check("abort.serial", {DSR, DSL, ser_rd}, 0);
        check("abort.q", q, 0);
        @(negedge CP);
        MR = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CP);
            if (done) done_cnt++;
        end
        check("abort.no_done", done_cnt, 0);
        $display("abort of SHR cnt=5 checked");

        do_cmd("shr3",   3'b010, 4'b0000, 4'd3,  1'b1, 3,  2'b01, 1'b1, 4'b1110);
        do_cmd("load",   3'b001, 4'b1010, 4'd7,  1'b0, 1,  2'b11, 1'b0, 4'b1010);
        do_cmd("rotr1",  3'b100, 4'b0000, 4'd1,  1'b1, 1,  2'b01, 1'b0, 4'b0101);
        do_cmd("rotr4",  3'b100, 4'b0000, 4'd4,  1'b1, 4,  2'b01, 1'b0, 4'b0101);
        do_cmd("load2",  3'b001, 4'b1000, 4'd0,  1'b0, 1,  2'b11, 1'b0, 4'b1000);
        do_cmd("shl1",   3'b011, 4'b0000, 4'd1,  1'b1, 1,  2'b10, 1'b1, 4'b0001);
        do_cmd("rotl1",  3'b101, 4'b0000, 4'd1,  1'b1, 1,  2'b10, 1'b0, 4'b0010);
        do_cmd("shr0",   3'b010, 4'b0000, 4'd0,  1'b1, 0,  2'b00, 1'b0, 4'b0010);
        do_cmd("nop",    3'b000, 4'b1111, 4'd5,  1'b1, 0,  2'b00, 1'b0, 4'b0010);
        do_cmd("ill7",   3'b111, 4'b1111, 4'd5,  1'b1, 0,  2'b00, 1'b0, 4'b0010);
        do_cmd("shr15",  3'b010, 4'b0000, 4'd15, 1'b0, 15, 2'b01, 1'b1, 4'b0000);

        // Two commands queued behind a continuously asserted cmd_valid.
        @(negedge CP);
        cmd_op = 3'b001; cmd_data = 4'b0110; cmd_cnt = 4'd0; cmd_valid = 1'b1;
        first_rdy = 0; done_cnt = 0; done_first = 0; done_last = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CP);
            if (k == 1) begin cmd_op = 3'b100; cmd_cnt = 4'd2; end
            if (done) begin done_cnt++; if (done_first == 0) done_first = k; done_last = k; end
            if (first_rdy != 0 && k == first_rdy + 1) begin
                check("hs.no_b2b", cmd_ready, 0);
                cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready && first_rdy == 0) first_rdy = k;
        end
        cmd_valid = 1'b0;
        check("hs.first_rdy", first_rdy, 3);
        check("hs.done_cnt", done_cnt, 2);
        check("hs.done_first", done_first, 2);
        check("hs.done_last", done_last, 6);
        check("hs.q", q, 4'b1001);
        $display("handshake LOAD 0110 then ROTR 2 Q=%b", q);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
